// File: rtl/taxel_aer_pkg.sv
// taxel_aer_pkg: shared types and helpers for the taxel AER readout.
// FSM states, default geometry and the round-robin first-set search.
package taxel_aer_pkg;

  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 8;
  localparam int DEF_SETTLE = 2;
  localparam int MAXN       = 64;

  typedef enum logic [2:0] {
    IDLE,
    ROW_ACK,
    COL_SEL,
    EMIT,
    CLEAR,
    HOLD,
    ROW_DONE
  } state_t;

  // First set bit of req[n-1:0] at or after ptr, wrapping to 0.
  function automatic int unsigned rr_first(
    input logic [MAXN-1:0] req,
    input int unsigned     ptr,
    input int unsigned     n
  );
    int unsigned idx;
    logic        found;
    rr_first = 0;
    found    = 1'b0;
    for (int unsigned i = 0; i < MAXN; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && req[idx[5:0]]) begin
        rr_first = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/taxel_aer_sync.sv
// taxel_aer_sync: multi-bit flop synchroniser for async latch outputs.
// STAGES flops deep, synchronous active-high reset.
module taxel_aer_sync #(
  parameter int W      = 64,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  // shift the sampled vector through the flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/taxel_aer_readout.sv
// taxel_aer_readout: row-scanned AER serialiser for OFF-channel taxels.
// Optional TAXEL_AER_TIMESTAMP_EN adds a per-row timestamp on ev_ts.
module taxel_aer_readout
  import taxel_aer_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int RW          = $clog2(ROWS),
  parameter int CW          = $clog2(COLS),
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = DEF_SETTLE
`ifdef TAXEL_AER_TIMESTAMP_EN
  ,
  parameter int TSW         = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] q_latch,
  output logic [ROWS-1:0]      acky,
  output logic [COLS-1:0]      ackx_pulse,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [RW-1:0]        ev_row,
  output logic [CW-1:0]        ev_col,
`ifdef TAXEL_AER_TIMESTAMP_EN
  output logic [TSW-1:0]       ev_ts,
`endif
  output logic                 busy
);

  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [ROWS*COLS-1:0] q_s;
  logic [ROWS-1:0]      row_any;
  logic [COLS-1:0]      cur_row;

  state_t          state_q, state_d;
  logic [RW-1:0]   sel_row_q, sel_row_d;
  logic [RW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   sel_col_q, sel_col_d;
  logic [COLS-1:0] col_pend_q, col_pend_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0] acky_q, acky_d;
  logic [COLS-1:0] ackx_q, ackx_d;
  logic            ev_valid_q, ev_valid_d;
  logic [RW-1:0]   ev_row_q, ev_row_d;
  logic [CW-1:0]   ev_col_q, ev_col_d;
`ifdef TAXEL_AER_TIMESTAMP_EN
  logic [TSW-1:0]  ts_cnt_q, ev_ts_q, ev_ts_d;
`endif

  taxel_aer_sync #(
    .W      (ROWS*COLS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (q_latch),
    .q   (q_s)
  );

  // per-row request summary and the selected row's column bits
  always_comb begin
    row_any = '0;
    for (int r = 0; r < ROWS; r++) row_any[r] = |q_s[r*COLS +: COLS];
    cur_row = q_s[sel_row_q*COLS +: COLS];
  end

  // next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    sel_row_d  = sel_row_q;
    rr_ptr_d   = rr_ptr_q;
    sel_col_d  = sel_col_q;
    col_pend_d = col_pend_q;
    cnt_d      = cnt_q;
    acky_d     = acky_q;
    ackx_d     = '0;
    ev_valid_d = ev_valid_q;
    ev_row_d   = ev_row_q;
    ev_col_d   = ev_col_q;
`ifdef TAXEL_AER_TIMESTAMP_EN
    ev_ts_d    = ev_ts_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|row_any) begin
          sel_row_d = RW'(rr_first(MAXN'(row_any),
                                   32'(rr_ptr_q), ROWS));
          acky_d    = '0;
          acky_d[sel_row_d] = 1'b1;
          cnt_d     = '0;
          state_d   = ROW_ACK;
        end
      end
      ROW_ACK: begin
        if (cnt_q == CNTW'(SETTLE-1)) begin
          col_pend_d = cur_row;
`ifdef TAXEL_AER_TIMESTAMP_EN
          ev_ts_d    = ts_cnt_q;
`endif
          if (|cur_row) begin
            state_d = COL_SEL;
          end else begin
            acky_d  = '0;
            state_d = ROW_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COL_SEL: begin
        sel_col_d  = CW'(rr_first(MAXN'(col_pend_q), 0, COLS));
        ev_row_d   = sel_row_q;
        ev_col_d   = sel_col_d;
        ev_valid_d = 1'b1;
        state_d    = EMIT;
      end
      EMIT: begin
        if (ev_ready) begin
          ev_valid_d        = 1'b0;
          ackx_d[sel_col_q] = 1'b1;
          state_d           = CLEAR;
        end
      end
      CLEAR: begin
        col_pend_d[sel_col_q] = 1'b0;
        cnt_d                 = '0;
        state_d               = HOLD;
      end
      HOLD: begin
        if (cnt_q == CNTW'(SETTLE-1)) begin
          if (|col_pend_q) begin
            state_d = COL_SEL;
          end else begin
            acky_d  = '0;
            state_d = ROW_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ROW_DONE: begin
        rr_ptr_d = (sel_row_q == RW'(ROWS-1)) ? '0 : sel_row_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_row_q  <= '0;
      rr_ptr_q   <= '0;
      sel_col_q  <= '0;
      col_pend_q <= '0;
      cnt_q      <= '0;
      acky_q     <= '0;
      ackx_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_row_q   <= '0;
      ev_col_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_row_q  <= sel_row_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_col_q  <= sel_col_d;
      col_pend_q <= col_pend_d;
      cnt_q      <= cnt_d;
      acky_q     <= acky_d;
      ackx_q     <= ackx_d;
      ev_valid_q <= ev_valid_d;
      ev_row_q   <= ev_row_d;
      ev_col_q   <= ev_col_d;
    end
  end

`ifdef TAXEL_AER_TIMESTAMP_EN
  // free-running timestamp and per-row captured value
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ev_ts_q  <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      ev_ts_q  <= ev_ts_d;
    end
  end

  assign ev_ts = ev_ts_q;
`endif

  assign acky       = acky_q;
  assign ackx_pulse = ackx_q;
  assign ev_valid   = ev_valid_q;
  assign ev_row     = ev_row_q;
  assign ev_col     = ev_col_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_taxel_aer_readout.sv
// tb_taxel_aer_readout: scoreboard bench with a behavioural taxel array.
// Latches clear on acky & ackx_pulse; set is gated by acky of the row.
module tb_taxel_aer_readout;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] c;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] latch = '0;
  logic [63:0] force_set;
  logic [63:0] blk, clr;
  logic [7:0]  acky, ackx_pulse;
  logic        ev_valid, ev_ready, busy;
  logic [2:0]  ev_row, ev_col;
`ifdef TAXEL_AER_TIMESTAMP_EN
  logic [15:0] ev_ts;
  logic [15:0] ts_q[$];
`endif

  ev_t exp_q[$];
  int  hs_cyc[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  n_ev = 0;
  int  acky_rise = 0;
  int  ackx_cnt = 0;
  logic [7:0] prev_acky = '0;
  logic [2:0] last_row = '0;
  logic [2:0] last_col = '0;

  always #5 clk = ~clk;

  taxel_aer_readout dut (
    .clk        (clk),
    .rst        (rst),
    .q_latch    (latch),
    .acky       (acky),
    .ackx_pulse (ackx_pulse),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_row     (ev_row),
    .ev_col     (ev_col),
`ifdef TAXEL_AER_TIMESTAMP_EN
    .ev_ts      (ev_ts),
`endif
    .busy       (busy)
  );

  always_comb begin
    blk = '0;
    clr = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        blk[r*8+c] = acky[r];
        clr[r*8+c] = acky[r] & ackx_pulse[c];
      end
  end

  always @(posedge clk)
    latch <= (latch | (force_set & ~blk)) & ~clr;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("ack_onehot",
            64'({$onehot0(acky), $onehot0(ackx_pulse),
                 (ackx_pulse == 0) || (acky != 0)}),
            64'd7);
        if (ev_valid && ev_ready) begin
          n_ev++;
          hs_cyc.push_back(cyc);
          last_row = ev_row;
          last_col = ev_col;
`ifdef TAXEL_AER_TIMESTAMP_EN
          ts_q.push_back(ev_ts);
`endif
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'({ev_row, ev_col}), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("event_addr", 64'({ev_row, ev_col}), 64'({e.r, e.c}));
          end
        end
        if (ackx_pulse != 0) begin
          ackx_cnt++;
          chk("ackx_match", 64'({acky, ackx_pulse}),
              64'({8'(1) << last_row, 8'(1) << last_col}));
        end
        if (acky != 0 && prev_acky == 0) acky_rise++;
      end
      prev_acky = acky;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_once(input logic [63:0] m);
    force_set = m;
    tick();
    force_set = '0;
  endtask

  task automatic push(input int r, input int c);
    ev_t e;
    e.r = 3'(r);
    e.c = 3'(c);
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!ev_valid && n < 50) begin
      tick();
      n++;
    end
    chk(nm, 64'(ev_valid), 64'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || latch != 0) && n < 400) begin
      tick();
      n++;
    end
    chk(nm, 64'(n < 400), 64'd1);
  endtask

  initial begin
    int n, base, ar, ax;
    logic ok;
    logic [2:0] r0, c0;
    rst = 1'b1;
    ev_ready = 1'b1;
    force_set = '0;
    repeat (3) tick();
    chk("rst_outs", 64'({acky, ackx_pulse, ev_valid, ev_row, ev_col, busy}),
        64'd0);
    rst = 1'b0;
    repeat (3) tick();

    // single event, row 3 col 5
    ar = acky_rise;
    ax = ackx_cnt;
    push(3, 5);
    set_once(64'd1 << 29);
    n = 0;
    while (!ev_valid && n < 30) begin
      tick();
      n++;
    end
    chk("single_latency", 64'(n), 64'd6);
    chk("single_acky", 64'(acky), 64'h08);
    wait_idle("single_idle");
    chk("single_rise", 64'(acky_rise - ar), 64'd1);
    chk("single_ackx", 64'(ackx_cnt - ax), 64'd1);
    repeat (10) tick();
    chk("single_no_more", 64'(n_ev), 64'd1);

    // row burst, row 2 cols 1 4 7
    ar = acky_rise;
    ax = ackx_cnt;
    base = hs_cyc.size();
    push(2, 1);
    push(2, 4);
    push(2, 7);
    set_once((64'd1 << 17) | (64'd1 << 20) | (64'd1 << 23));
    wait_idle("burst_idle");
    chk("burst_n", 64'(hs_cyc.size() - base), 64'd3);
    if (hs_cyc.size() - base == 3) begin
      chk("burst_gap0", 64'(hs_cyc[base+1] - hs_cyc[base]), 64'd5);
      chk("burst_gap1", 64'(hs_cyc[base+2] - hs_cyc[base+1]), 64'd5);
`ifdef TAXEL_AER_TIMESTAMP_EN
      chk("burst_ts", 64'({ts_q[base+1] == ts_q[base],
                           ts_q[base+2] == ts_q[base]}), 64'd3);
`endif
    end
    chk("burst_rise", 64'(acky_rise - ar), 64'd1);
    chk("burst_ackx", 64'(ackx_cnt - ax), 64'd3);
    chk("burst_acky_off", 64'(acky), 64'd0);

    // round robin, rows 0 and 5 continuously re-set
    for (int i = 0; i < 3; i++) begin
      push(5, 6);
      push(0, 2);
    end
    force_set = (64'd1 << 2) | (64'd1 << 46);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("rr_served", 64'(n < 500), 64'd1);
    force_set = '0;
    push(5, 6);
    wait_idle("rr_idle");

    // backpressure on row 6 col 0
    ax = ackx_cnt;
    ev_ready = 1'b0;
    push(6, 0);
    set_once(64'd1 << 48);
    wait_valid("bp_valid");
    r0 = ev_row;
    c0 = ev_col;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!ev_valid || ev_row != r0 || ev_col != c0 || ackx_pulse != 0)
        ok = 1'b0;
    end
    chk("bp_stable", 64'(ok), 64'd1);
    chk("bp_addr", 64'({r0, c0}), 64'({3'd6, 3'd0}));
    chk("bp_no_ackx", 64'(ackx_cnt - ax), 64'd0);
    ev_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_ackx", 64'(ackx_cnt - ax), 64'd1);

    // reset while EMIT waits on row 1 col 3
    ev_ready = 1'b0;
    push(1, 3);
    set_once(64'd1 << 11);
    wait_valid("rst_valid");
    rst = 1'b1;
    tick();
    chk("rst_mid", 64'({acky, ackx_pulse, ev_valid, busy}), 64'd0);
    rst = 1'b0;
    ev_ready = 1'b1;
    wait_idle("rst_idle");

    repeat (20) tick();
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    chk("final_events", 64'(n_ev), 64'd13);
    chk("final_valid", 64'(ev_valid), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
